// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced push-button conditioner with press/release/long-press pulses
// Optional long-press detector enabled by defining macro BTN_LONG_PRESS_EN.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16000,
  parameter int unsigned LONG_PRESS_CYCLES = 16000000,
  parameter int unsigned BTN_ACTIVE_LOW    = 0
) (
  input  logic clk_16mhz,
  input  logic rst_n,
  input  logic btn_usr,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Transition happens on the edge where the count would reach DEBOUNCE_CYCLES,
  // which gives exactly 2+DEBOUNCE_CYCLES edges from pin to btn_level.
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM_PRESS,
    S_HELD,
    S_ARM_RELEASE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_sync;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic            w_btn_in;
  logic            w_btn_sync;
  logic            w_press_accept;
  logic            w_release_accept;

  // Polarity is normalised ahead of the synchronizer so that the reset value
  // of the sync flops (0) always means "released" and never fakes a press.
  assign w_btn_in   = (BTN_ACTIVE_LOW != 0) ? ~btn_usr : btn_usr;
  assign w_btn_sync = r_sync[1];

  assign w_press_accept   = (r_state == S_ARM_PRESS)   &&  w_btn_sync && (r_cnt == C_LAST);
  assign w_release_accept = (r_state == S_ARM_RELEASE) && !w_btn_sync && (r_cnt == C_LAST);

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], w_btn_in};
    end
  end

  // Debounce FSM with registered level and edge pulses.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_btn_sync) begin
            r_state <= S_ARM_PRESS;
            r_cnt   <= CW'(1);
          end
        end
        S_ARM_PRESS: begin
          if (!w_btn_sync) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HELD: begin
          if (!w_btn_sync) begin
            r_state <= S_ARM_RELEASE;
            r_cnt   <= CW'(1);
          end
        end
        S_ARM_RELEASE: begin
          if (w_btn_sync) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic [HW-1:0] r_hold;
  logic          r_long;

  // Hold counter: cleared only on a new accepted press, so a release bounce
  // that falls back into HELD cannot re-arm the long-press pulse.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_press_accept) begin
        r_hold <= '0;
      end else if (((r_state == S_HELD) || (r_state == S_ARM_RELEASE)) &&
                   !w_release_accept && (r_hold != H_MAX)) begin
        r_hold <= r_hold + HW'(1);
        if (r_hold == H_LAST) begin
          r_long <= 1'b1;
        end
      end
    end
  end

  assign btn_long = r_long;
`else
  assign btn_long = 1'b0;
`endif

endmodule
